// File: rtl/fismos_bus_ctrl_if.sv
// rtl/fismos_bus_ctrl_if.sv - CPU, slave and error-status signal bundle for fismos_bus_ctrl
interface fismos_bus_ctrl_if;
  logic        cpu_valid;
  logic        cpu_instr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic [31:0] tgt_addr;
  logic [31:0] tgt_wdata;
  logic [3:0]  tgt_wstrb;
  logic        ram_valid;
  logic        io_valid;
  logic        shm_valid;
  logic        ram_ready;
  logic        io_ready;
  logic        shm_ready;
  logic [31:0] ram_rdata;
  logic [31:0] shm_rdata;
  logic        err_clear;
  logic        err_irq;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;
  logic [7:0]  err_count;

  // master: the controller side; slave: CPU, slaves and status consumer
  modport master (
    input  cpu_valid, cpu_instr, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata,
    output tgt_addr, tgt_wdata, tgt_wstrb,
    output ram_valid, io_valid, shm_valid,
    input  ram_ready, io_ready, shm_ready, ram_rdata, shm_rdata,
    input  err_clear,
    output err_irq, err_cause, err_addr, err_count
  );

  modport slave (
    output cpu_valid, cpu_instr, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata,
    input  tgt_addr, tgt_wdata, tgt_wstrb,
    input  ram_valid, io_valid, shm_valid,
    output ram_ready, io_ready, shm_ready, ram_rdata, shm_rdata,
    output err_clear,
    input  err_irq, err_cause, err_addr, err_count
  );
endinterface

// File: rtl/fismos_bus_ctrl.sv
// rtl/fismos_bus_ctrl.sv - single-master decode, slave select, watchdog and error status
module fismos_bus_ctrl #(
  parameter int unsigned RAM_BYTES      = 16384,
  parameter logic [31:0] IO_BASE        = 32'h1000_0000,
  parameter logic [31:0] SHM_BASE       = 32'h2000_0000,
  parameter int unsigned SHM_BYTES      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hBADC_0DE5
) (
  input logic            clk_i,
  input logic            reset_i,
  fismos_bus_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_e;

  state_e      state_q, state_d;
  logic [31:0] tgt_addr_q, tgt_addr_d, tgt_wdata_q, tgt_wdata_d;
  logic [3:0]  tgt_wstrb_q, tgt_wstrb_d;
  logic [2:0]  sel_q, sel_d;  // {shm, io, ram}
  logic [15:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  pend_q, pend_d;
  logic        irq_q, irq_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] eaddr_q, eaddr_d;
  logic [7:0]  ecount_q, ecount_d;

  logic       hit_ram, hit_io, hit_shm, sel_ready;
  logic [2:0] slave_ready;

  assign hit_ram     = bus.cpu_addr < 32'(RAM_BYTES);
  assign hit_io      = bus.cpu_addr[31:4] == IO_BASE[31:4];
  // unsigned wrap makes addresses below SHM_BASE fail the compare
  assign hit_shm     = (bus.cpu_addr - SHM_BASE) < 32'(SHM_BYTES);
  assign slave_ready = {bus.shm_ready, bus.io_ready, bus.ram_ready};
  assign sel_ready   = |(sel_q & slave_ready);

  always_comb begin
    state_d     = state_q;
    tgt_addr_d  = tgt_addr_q;
    tgt_wdata_d = tgt_wdata_q;
    tgt_wstrb_d = tgt_wstrb_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    pend_d      = pend_q;
    cause_d     = cause_q;
    eaddr_d     = eaddr_q;
    ecount_d    = ecount_q;
    irq_d       = bus.err_clear ? 1'b0 : irq_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_valid) begin
          tgt_addr_d  = bus.cpu_addr;
          tgt_wdata_d = bus.cpu_wdata;
          tgt_wstrb_d = bus.cpu_wstrb;
          cnt_d       = '0;
          if (!(hit_ram || hit_io || hit_shm)) begin
            state_d = ERR;
            pend_d  = 2'b01;
            ready_d = 1'b1;
            rdata_d = ERR_RDATA;
          end else if (bus.cpu_instr && !hit_ram) begin
            state_d = ERR;
            pend_d  = 2'b11;
            ready_d = 1'b1;
            rdata_d = ERR_RDATA;
          end else begin
            state_d = WAIT;
            sel_d   = {hit_shm, hit_io, hit_ram};
          end
        end
      end
      WAIT: begin
        if (sel_ready) begin
          state_d = RESP;
          sel_d   = '0;
          ready_d = 1'b1;
          rdata_d = sel_q[0] ? bus.ram_rdata : (sel_q[2] ? bus.shm_rdata : 32'h0);
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERR;
          sel_d   = '0;
          ready_d = 1'b1;
          rdata_d = ERR_RDATA;
          pend_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: state_d = IDLE;
      ERR: begin
        state_d  = IDLE;
        cause_d  = pend_q;
        eaddr_d  = tgt_addr_q;
        ecount_d = (ecount_q == 8'hFF) ? ecount_q : ecount_q + 8'd1;
        irq_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      tgt_addr_q  <= '0;
      tgt_wdata_q <= '0;
      tgt_wstrb_q <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      pend_q      <= '0;
      irq_q       <= 1'b0;
      cause_q     <= '0;
      eaddr_q     <= '0;
      ecount_q    <= '0;
    end else begin
      state_q     <= state_d;
      tgt_addr_q  <= tgt_addr_d;
      tgt_wdata_q <= tgt_wdata_d;
      tgt_wstrb_q <= tgt_wstrb_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      pend_q      <= pend_d;
      irq_q       <= irq_d;
      cause_q     <= cause_d;
      eaddr_q     <= eaddr_d;
      ecount_q    <= ecount_d;
    end
  end

  assign bus.cpu_ready = ready_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.tgt_addr  = tgt_addr_q;
  assign bus.tgt_wdata = tgt_wdata_q;
  assign bus.tgt_wstrb = tgt_wstrb_q;
  assign bus.ram_valid = sel_q[0];
  assign bus.io_valid  = sel_q[1];
  assign bus.shm_valid = sel_q[2];
  assign bus.err_irq   = irq_q;
  assign bus.err_cause = cause_q;
  assign bus.err_addr  = eaddr_q;
  assign bus.err_count = ecount_q;
endmodule

// File: tb/tb_fismos_bus_ctrl.sv
// tb/tb_fismos_bus_ctrl.sv - randomized transaction-level bench for fismos_bus_ctrl
module tb_fismos_bus_ctrl;
  localparam int unsigned RAM_BYTES = 16384;
  localparam logic [31:0] IO_BASE   = 32'h1000_0000;
  localparam logic [31:0] SHM_BASE  = 32'h2000_0000;
  localparam int unsigned SHM_BYTES = 4096;
  localparam int          TO        = 8;
  localparam logic [31:0] ERR_RD    = 32'hBADC_0DE5;

  logic clk = 1'b0;
  logic reset;
  int n_checks = 0;
  int n_errors = 0;

  logic        m_irq;
  logic [1:0]  m_cause;
  logic [31:0] m_addr;
  int          m_count;

  fismos_bus_ctrl_if bus ();

  fismos_bus_ctrl #(
    .RAM_BYTES(RAM_BYTES), .IO_BASE(IO_BASE), .SHM_BASE(SHM_BASE),
    .SHM_BYTES(SHM_BYTES), .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR_RD)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 unmapped, 1 RAM, 2 IO, 3 SHM
  function automatic int region_of(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    if (ua < longint'(RAM_BYTES)) return 1;
    if (ua >= longint'(IO_BASE) && ua < longint'(IO_BASE) + 16) return 2;
    if (ua >= longint'(SHM_BASE) && ua < longint'(SHM_BASE) + longint'(SHM_BYTES)) return 3;
    return 0;
  endfunction

  task automatic quiet_inputs();
    bus.cpu_valid = 1'b0; bus.cpu_instr = 1'b0; bus.cpu_addr = '0;
    bus.cpu_wdata = '0;   bus.cpu_wstrb = '0;
    bus.ram_ready = 1'b0; bus.io_ready = 1'b0; bus.shm_ready = 1'b0;
    bus.ram_rdata = '0;   bus.shm_rdata = '0;  bus.err_clear = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_irq"},   32'(bus.err_irq),   32'(m_irq));
    check_eq({tag, "_cause"}, 32'(bus.err_cause), 32'(m_cause));
    check_eq({tag, "_eaddr"}, bus.err_addr,       m_addr);
    check_eq({tag, "_count"}, 32'(bus.err_count), 32'(m_count));
  endtask

  // Called #1 after a rising edge; that cycle is cycle 0 of the access.
  // dly = valid cycle on which the selected slave answers (0 = never).
  task automatic do_access(input string tag, input logic [31:0] a, input logic instr,
                           input logic [3:0] ws, input int dly, input logic [31:0] rdv,
                           input logic clr);
    int          reg_n, exp_lat, exp_vcyc, vcnt, lat;
    logic [1:0]  cause;
    logic [31:0] exp_rd, wd;
    logic [2:0]  sel, noise;
    logic        bad_sel, bad_tgt;
    reg_n = region_of(a);
    wd    = $urandom;
    cause = 2'b00;
    if (reg_n == 0) cause = 2'b01;
    else if (instr && reg_n != 1) cause = 2'b11;
    if (cause != 0) begin
      exp_lat = 1; exp_vcyc = 0; exp_rd = ERR_RD;
    end else if (dly >= 1 && dly <= TO) begin
      exp_lat = dly + 1; exp_vcyc = dly; exp_rd = (reg_n == 2) ? 32'h0 : rdv;
    end else begin
      exp_lat = TO + 1; exp_vcyc = TO; exp_rd = ERR_RD; cause = 2'b10;
    end
    bus.cpu_valid = 1'b1; bus.cpu_instr = instr; bus.cpu_addr = a;
    bus.cpu_wdata = wd;   bus.cpu_wstrb = ws;
    vcnt = 0; lat = 0; bad_sel = 1'b0; bad_tgt = 1'b0;
    for (int c = 1; c <= TO + 6 && lat == 0; c++) begin
      @(posedge clk); #1;
      sel = {bus.shm_valid, bus.io_valid, bus.ram_valid};
      if (sel != 3'b000) begin
        vcnt++;
        if (reg_n == 0 || sel != (3'b001 << (reg_n - 1))) bad_sel = 1'b1;
        if (bus.tgt_addr !== a || bus.tgt_wdata !== wd || bus.tgt_wstrb !== ws) bad_tgt = 1'b1;
      end
      noise = 3'($urandom);
      bus.ram_ready = noise[0] & ~sel[0];
      bus.io_ready  = noise[1] & ~sel[1];
      bus.shm_ready = noise[2] & ~sel[2];
      bus.ram_rdata = $urandom;
      bus.shm_rdata = $urandom;
      if (sel != 3'b000 && vcnt == dly) begin
        if (sel[0]) begin bus.ram_ready = 1'b1; bus.ram_rdata = rdv; end
        if (sel[1]) bus.io_ready = 1'b1;
        if (sel[2]) begin bus.shm_ready = 1'b1; bus.shm_rdata = rdv; end
      end
      bus.err_clear = (c == exp_lat) ? clr : 1'b0;
      if (bus.cpu_ready) begin
        lat = c;
        check_eq({tag, "_rdata"}, bus.cpu_rdata, exp_rd);
      end
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    quiet_inputs();
    if (cause != 0) begin
      m_irq = 1'b1; m_cause = cause; m_addr = a;
      if (m_count < 255) m_count++;
    end else if (clr) begin
      m_irq = 1'b0;
    end
    check_eq({tag, "_ready_pulse"}, 32'(bus.cpu_ready), 32'h0);
    check_eq({tag, "_valid_cycles"}, 32'(vcnt), 32'(exp_vcyc));
    check_eq({tag, "_onehot"}, 32'(bad_sel), 32'h0);
    check_eq({tag, "_tgt_stable"}, 32'(bad_tgt), 32'h0);
    check_status(tag);
  endtask

  initial begin
    logic [31:0] ua;
    logic [31:0] edges [6];
    edges = '{32'(RAM_BYTES), SHM_BASE + 32'(SHM_BYTES), IO_BASE + 32'd16,
              IO_BASE - 32'd1, SHM_BASE - 32'd1, 32'hFFFF_FFFF};
    m_irq = 1'b0; m_cause = 2'b00; m_addr = '0; m_count = 0;
    quiet_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(bus.cpu_ready), 32'h0);
    check_eq("rst_rdata", bus.cpu_rdata, 32'h0);
    check_eq("rst_valids", 32'({bus.shm_valid, bus.io_valid, bus.ram_valid}), 32'h0);
    check_eq("rst_tgt_addr", bus.tgt_addr, 32'h0);
    check_status("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    do_access("ram_rd", 32'h0000_0100, 1'b0, 4'b0000, 1, 32'h1234_5678, 1'b0);
    do_access("shm_wr", 32'h2000_0010, 1'b0, 4'b0011, 5, 32'h0, 1'b0);
    do_access("unmapped", 32'h3000_0000, 1'b0, 4'b0000, 1, 32'h0, 1'b0);
    do_access("io_timeout", 32'h1000_0004, 1'b0, 4'b1111, 0, 32'h0, 1'b0);
    do_access("io_last", 32'h1000_0008, 1'b0, 4'b1111, TO, 32'h0, 1'b1);
    do_access("ram_fetch", 32'h0000_3FFC, 1'b1, 4'b0000, 2, 32'hCAFE_F00D, 1'b0);
    do_access("bad_fetch", 32'h2000_0000, 1'b1, 4'b0000, 1, 32'h0, 1'b0);
    for (int i = 0; i < 256; i++)
      do_access("sat", 32'h4000_0000 + 32'(i), 1'b0, 4'b0000, 1, 32'h0, 1'(i % 2));
    do_access("clr_vs_set", 32'h0000_4000, 1'b0, 4'b0000, 1, 32'h0, 1'b1);

    bus.cpu_valid = 1'b1; bus.cpu_addr = 32'h0000_0200;
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_rst_in_wait", 32'(bus.ram_valid), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    quiet_inputs();
    check_eq("mid_rst_valid", 32'({bus.shm_valid, bus.io_valid, bus.ram_valid}), 32'h0);
    check_eq("mid_rst_ready", 32'(bus.cpu_ready), 32'h0);
    m_irq = 1'b0; m_cause = 2'b00; m_addr = '0; m_count = 0;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("mid_rst_no_resp", 32'(bus.cpu_ready | bus.ram_valid), 32'h0);
    end
    check_status("mid_rst");
    do_access("post_rst_ram", 32'h0000_0040, 1'b0, 4'b0000, 3, 32'h0BAD_BEEF, 1'b0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: ua = 32'($urandom_range(0, RAM_BYTES - 1));
        1: ua = IO_BASE | 32'($urandom_range(0, 15));
        2: ua = SHM_BASE + 32'($urandom_range(0, SHM_BYTES - 1));
        3: ua = edges[$urandom_range(0, 5)];
        default: ua = $urandom;
      endcase
      do_access("rand", ua, 1'($urandom_range(0, 3) == 0), 4'($urandom),
                $urandom_range(0, TO + 2), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
